// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - two-port (icache/dcache) to one physical memory port burst arbiter
// Optional round-robin tie-break is compiled in with `define PMEM_ARB_RR_EN.
module pmem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int BURST_W = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    // icache side
    input  logic               i_pmem_read,
    input  logic               i_pmem_write,
    input  logic [ADDR_W-1:0]  i_pmem_address,
    input  logic [BURST_W-1:0] i_pmem_wdata,
    output logic               i_pmem_resp,
    output logic [BURST_W-1:0] i_pmem_rdata,
    // dcache side
    input  logic               d_pmem_read,
    input  logic               d_pmem_write,
    input  logic [ADDR_W-1:0]  d_pmem_address,
    input  logic [BURST_W-1:0] d_pmem_wdata,
    output logic               d_pmem_resp,
    output logic [BURST_W-1:0] d_pmem_rdata,
    // physical memory port
    output logic               mem_read,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [BURST_W-1:0] mem_wdata,
    input  logic               mem_resp,
    input  logic [BURST_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, TURN} state_t;

    state_t             state_q;
    logic               mem_read_q;
    logic               mem_write_q;
    logic [ADDR_W-1:0]  mem_address_q;
    logic [BURST_W-1:0] mem_wdata_q;

    logic               i_req;
    logic               d_req;
    logic               pick_d;
    logic               sel_read;
    logic               sel_write;
    logic [ADDR_W-1:0]  sel_address;
    logic [BURST_W-1:0] sel_wdata;

    assign i_req = i_pmem_read | i_pmem_write;
    assign d_req = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARB_RR_EN
    // Set when D wins the next tie; flips to the side not just served.
    logic prio_d_q;
    assign pick_d = d_req & (~i_req | prio_d_q);
`else
    assign pick_d = d_req;
`endif

    assign sel_read    = pick_d ? d_pmem_read    : i_pmem_read;
    assign sel_write   = pick_d ? d_pmem_write   : i_pmem_write;
    assign sel_address = pick_d ? d_pmem_address : i_pmem_address;
    assign sel_wdata   = pick_d ? d_pmem_wdata   : i_pmem_wdata;

    // Arbitration FSM; latches the winner's request for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
`ifdef PMEM_ARB_RR_EN
            prio_d_q      <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req | d_req) begin
                        state_q       <= pick_d ? GRANT_D : GRANT_I;
                        // A write-back request that also asserts read is a write.
                        mem_write_q   <= sel_write;
                        mem_read_q    <= sel_read & ~sel_write;
                        mem_address_q <= sel_address;
                        mem_wdata_q   <= sel_wdata;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (mem_resp) begin
                        state_q     <= TURN;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
`ifdef PMEM_ARB_RR_EN
                        prio_d_q    <= (state_q == GRANT_I);
`endif
                    end
                end
                TURN: begin
                    // Gives the served cache a cycle to drop its request.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;

    // Completion is forwarded combinationally, only to the granted side.
    assign i_pmem_resp  = (state_q == GRANT_I) & mem_resp;
    assign d_pmem_resp  = (state_q == GRANT_D) & mem_resp;
    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - scoreboard bench for pmem_arbiter
module tb_pmem_arbiter;

    localparam int AW = 16;
    localparam int BW = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_pmem_read, i_pmem_write;
    logic [AW-1:0] i_pmem_address;
    logic [BW-1:0] i_pmem_wdata;
    logic          i_pmem_resp;
    logic [BW-1:0] i_pmem_rdata;
    logic          d_pmem_read, d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [BW-1:0] d_pmem_wdata;
    logic          d_pmem_resp;
    logic [BW-1:0] d_pmem_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_wdata;
    logic          mem_resp;
    logic [BW-1:0] mem_rdata;

    pmem_arbiter #(.ADDR_W(AW), .BURST_W(BW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_write   (i_pmem_write),
        .i_pmem_address (i_pmem_address),
        .i_pmem_wdata   (i_pmem_wdata),
        .i_pmem_resp    (i_pmem_resp),
        .i_pmem_rdata   (i_pmem_rdata),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_resp    (d_pmem_resp),
        .d_pmem_rdata   (d_pmem_rdata),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_resp       (mem_resp),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          side_d;
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic side_d, input logic wr, input logic [AW-1:0] addr,
                        input logic [BW-1:0] wdata);
        exp_t e;
        e.side_d = side_d;
        e.wr     = wr;
        e.addr   = addr;
        e.wdata  = wdata;
        sb.push_back(e);
    endtask

    // Memory model: waits for a grant, checks it against the scoreboard,
    // responds after `delay` cycles and checks the response routing.
    task automatic serve(input int delay, input logic [BW-1:0] pat, input logic drop,
                         output int waited);
        exp_t e;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(mem_read | mem_write) && waited < 10);
        chk("grant_seen", mem_read | mem_write, 1);
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("mem_address", mem_address, e.addr);
            chk("mem_write", mem_write, e.wr);
            chk("mem_read", mem_read, !e.wr);
            if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
            repeat (delay - 1) begin
                @(negedge clk);
                chk("hold_address", mem_address, e.addr);
                chk("no_early_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
            end
            @(negedge clk);
            mem_rdata = pat;
            mem_resp  = 1'b1;
            #1;
            chk("i_resp", i_pmem_resp, !e.side_d);
            chk("d_resp", d_pmem_resp, e.side_d);
            chk("rdata", e.side_d ? d_pmem_rdata : i_pmem_rdata, pat);
            if (drop) begin
                if (e.side_d) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
                else begin i_pmem_read = 1'b0; i_pmem_write = 1'b0; end
            end
            @(negedge clk);
            mem_resp = 1'b0;
            chk("strobes_after_resp", {mem_read, mem_write}, 2'b00);
        end
    endtask

    initial begin
        int           w;
        exp_t         e;
        logic [BW-1:0] pat_a, pat_b, wd_a5;
        pat_a = {8{32'hDEADBEEF}};
        pat_b = {16{16'h1234}};
        wd_a5 = {32{8'hA5}};

        rst_n = 1'b0;
        i_pmem_read = 0; i_pmem_write = 0; i_pmem_address = '0; i_pmem_wdata = '0;
        d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
        mem_resp = 0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_strobes", {mem_read, mem_write}, 2'b00);
        chk("rst_address", mem_address, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);

        // Single icache read
        i_pmem_read = 1; i_pmem_address = 16'h1240;
        push(0, 0, 16'h1240, '0);
        serve(5, pat_a, 1, w);
        chk("grant_latency", w, 1);
        repeat (2) @(negedge clk);

        // Simultaneous i read / d write: D first, I two cycles after D resp
        i_pmem_read = 1; i_pmem_address = 16'h0100;
        d_pmem_write = 1; d_pmem_address = 16'h2200; d_pmem_wdata = wd_a5;
        push(1, 1, 16'h2200, wd_a5);
        push(0, 0, 16'h0100, '0);
        serve(3, pat_b, 1, w);
        serve(2, pat_a, 1, w);
        chk("turn_gap", w, 2);
        repeat (2) @(negedge clk);

        // Continuous requests from both sides for four transactions
        i_pmem_read = 1; i_pmem_address = 16'h0A00;
        d_pmem_read = 1; d_pmem_address = 16'h0B00;
`ifdef PMEM_ARB_RR_EN
        push(1, 0, 16'h0B00, '0); push(0, 0, 16'h0A00, '0);
        push(1, 0, 16'h0B00, '0); push(0, 0, 16'h0A00, '0);
`else
        for (int k = 0; k < 4; k++) push(1, 0, 16'h0B00, '0);
`endif
        for (int k = 0; k < 4; k++) begin
            serve(2, pat_b ^ BW'(k), 0, w);
            if (k != 0) chk("b2b_gap", w, 2);
        end
        i_pmem_read = 0; d_pmem_read = 0;
        repeat (2) @(negedge clk);
        chk("idle_after_b2b", {mem_read, mem_write}, 2'b00);

        // Address change mid-GRANT_D is ignored
        d_pmem_write = 1; d_pmem_address = 16'h2200; d_pmem_wdata = wd_a5;
        push(1, 1, 16'h2200, wd_a5);
        e = sb.pop_front();
        @(negedge clk);
        chk("midg_write", mem_write, 1);
        chk("midg_addr0", mem_address, e.addr);
        d_pmem_address = 16'h3300;
        repeat (3) begin
            @(negedge clk);
            chk("midg_hold", mem_address, e.addr);
        end
        mem_resp = 1; mem_rdata = pat_a;
        #1;
        chk("midg_resp", {i_pmem_resp, d_pmem_resp}, 2'b01);
        chk("midg_addr_at_resp", mem_address, e.addr);
        d_pmem_write = 0;
        @(negedge clk);
        mem_resp = 0;
        chk("midg_strobes_off", {mem_read, mem_write}, 2'b00);
        repeat (2) @(negedge clk);

        // Read and write both high: write wins
        d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 16'h4000; d_pmem_wdata = pat_b;
        push(1, 1, 16'h4000, pat_b);
        serve(2, pat_a, 1, w);
        repeat (2) @(negedge clk);

        // mem_resp while IDLE is ignored
        mem_resp = 1;
        #1;
        chk("idle_resp_fwd", {i_pmem_resp, d_pmem_resp}, 2'b00);
        @(negedge clk);
        mem_resp = 0;
        chk("idle_resp_strobes", {mem_read, mem_write}, 2'b00);
        i_pmem_read = 1; i_pmem_address = 16'h0555;
        push(0, 0, 16'h0555, '0);
        serve(2, pat_b, 1, w);
        chk("idle_resp_latency", w, 1);
        repeat (2) @(negedge clk);

        // Reset two cycles into a granted read
        i_pmem_read = 1; i_pmem_address = 16'h0777;
        @(negedge clk);
        chk("rstmid_granted", mem_read, 1);
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("rstmid_async_drop", mem_read, 0);
        mem_resp = 1;
        #1;
        chk("rstmid_no_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
        mem_resp = 0;
        i_pmem_read = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rstmid_idle", {mem_read, mem_write}, 2'b00);
        d_pmem_read = 1; d_pmem_address = 16'h0888;
        push(1, 0, 16'h0888, '0);
        serve(3, pat_a, 1, w);
        chk("rstmid_regrant", w, 1);

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Sits directly downstream of the instruction and data cache datapaths.
- Consumes each cache's pmem_address, pmem_wdata and pmem read/write strobes, and grants one 256-bit burst transaction at a time to the single physical memory port.
- Returns mem_rdata and a response pulse to the granted cache only.
- Latches the granted request so the memory sees stable address, data and strobes for the whole transaction.

Parameters:
- ADDR_W, 16, width of the lc3b_word address.
- BURST_W, 256, width of the lc3b_burst line.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_pmem_read  in  1  icache line-fill request.
- i_pmem_write  in  1  icache write request (unused by icache; tie 0, still arbitrated).
- i_pmem_address  in  16  icache line address.
- i_pmem_wdata  in  256  icache write burst.
- i_pmem_resp  out  1  icache transaction complete.
- i_pmem_rdata  out  256  icache fill data.
- d_pmem_read  in  1  dcache line-fill request.
- d_pmem_write  in  1  dcache write-back request.
- d_pmem_address  in  16  dcache line address.
- d_pmem_wdata  in  256  dcache write-back burst.
- d_pmem_resp  out  1  dcache transaction complete.
- d_pmem_rdata  out  256  dcache fill data.
- mem_read  out  1  physical memory read strobe.
- mem_write  out  1  physical memory write strobe.
- mem_address  out  16  physical memory address.
- mem_wdata  out  256  physical memory write burst.
- mem_resp  in  1  physical memory done.
- mem_rdata  in  256  physical memory read burst.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - mem_read, mem_write, mem_address, mem_wdata = 0.
  - Both resp outputs = 0.
  - Priority pointer = D.
- States: IDLE, GRANT_I, GRANT_D, TURN.
- IDLE:
  - A side requests when its read|write is high.
  - If only one side requests, grant it.
  - If both request, grant D (fixed priority unless the optional feature is compiled in).
  - On grant edge, register the winner's address and wdata into mem_address/mem_wdata, and its read/write into mem_read/mem_write.
  - If read and write are both high on one side, write wins: mem_write=1, mem_read=0.
  - Memory strobes assert the cycle after the request is first seen (1-cycle grant latency).
- GRANT_x:
  - Hold mem_* registers constant. Ignore changes on the requester's inputs.
  - When mem_resp=1, the granted side's x_pmem_resp=1 combinationally in the same cycle.
  - In that same cycle, x_pmem_rdata = mem_rdata. The other side's resp stays 0.
  - The next edge clears mem_read/mem_write and moves to TURN.
- TURN:
  - One idle cycle with no grant.
  - Lets the served cache deassert its request after seeing resp, so a stale request is not regranted.
  - Always moves to IDLE.
- Back-to-back requests: minimum gap between two memory transactions is 2 cycles (TURN + IDLE grant).
- rdata:
  - x_pmem_rdata is driven with mem_rdata at all times.
  - Only the qualifying resp has meaning.
- Requester drops its request mid-GRANT (protocol violation):
  - Transaction still completes on mem_resp.
  - resp is still pulsed to that side.
- mem_resp while in IDLE or TURN: ignored, no resp forwarded.
- Reset mid-transaction:
  - Strobes drop immediately (asynchronously).
  - No resp is generated.
  - Memory is reset by the same rst_n.
- No other buffering. At most one outstanding transaction.

Optional Feature:
- Macro: PMEM_ARB_RR_EN.
- Defined:
  - A 1-bit priority pointer selects the winner on simultaneous requests.
  - After any completed transaction, the pointer points to the side not just served.
  - Reset value of the pointer is D.
- Undefined:
  - The D side always wins simultaneous requests.
  - The pointer register is not synthesized.

Test Plan:
- Single icache read, addr 0x1240, memory responds after 5 cycles with a known pattern:
  - mem_read=1, mem_address=0x1240 one cycle after request.
  - i_pmem_resp=1 exactly in the mem_resp cycle with i_pmem_rdata = pattern.
  - d_pmem_resp stays 0.
  - mem_read=0 next cycle.
- Simultaneous i read 0x0100 and d write 0x2200, wdata = 0xA5 repeated:
  - D granted first (mem_write=1, mem_address=0x2200).
  - After d_pmem_resp, TURN then IDLE.
  - I then granted, so mem_address=0x0100 appears 2 cycles after the D response.
- Both sides hold requests continuously for 4 transactions:
  - Without PMEM_ARB_RR_EN the order is D,D,D,D.
  - With it the order is D,I,D,I.
- Change d_pmem_address from 0x2200 to 0x3300 mid-GRANT_D:
  - mem_address stays 0x2200 until resp.
- Assert rst_n=0 two cycles into a granted read:
  - mem_read drops without a clock edge.
  - No resp is pulsed; state is IDLE after release.
  - A new request is granted normally.
- d_pmem_read and d_pmem_write both high, address 0x4000:
  - mem_write=1, mem_read=0.
- mem_resp pulsed while IDLE:
  - No resp on either side, no state change.
